// File: rtl/stitch_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stitch_arb_pkg
//  Description : Shared types, constants and helpers for stitch_pipe_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package stitch_arb_pkg;

    // Bit count needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int CNT_W    = 16;
    localparam int MAX_NREQ = 16;
    // Index width sized for the largest supported requester count; unused
    // upper bits simply stay zero for smaller configurations.
    localparam int IDXW     = clog2_min1(MAX_NREQ);

    // One in-flight issue: occupied flag plus the requester it belongs to.
    typedef struct packed {
        logic            vld;
        logic [IDXW-1:0] idx;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/stitch_pipe_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : stitch_pipe_arbiter_if
//  Description : Request, pipeline and response signals of the arbiter.
//                slave = arbiter side, master = requesters + pipeline side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stitch_pipe_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int RW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               pipe_in_valid;
    logic [DW-1:0]      pipe_in_data;
    logic               pipe_out_valid;
    logic [RW-1:0]      pipe_out_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [RW-1:0]      rsp_data;
    logic               err_tag;

    modport slave (
        input  req_valid, req_data, pipe_out_valid, pipe_out_data,
        output req_ready, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, err_tag
    );

    modport master (
        output req_valid, req_data, pipe_out_valid, pipe_out_data,
        input  req_ready, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, err_tag
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Registered pointer plus a combinational
//                wrap-around priority search; one-hot grant and its index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import stitch_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,        // asynchronous, active-low
    input  wire logic [NREQ-1:0] req_valid,
    output logic      [NREQ-1:0] grant,
    output logic      [IDXW-1:0] grant_idx,
    output logic                 grant_any
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;

    // Search upward from the pointer first, then wrap to the low indices.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_any && (IDXW'(j) >= ptr_q) && req_valid[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDXW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_any && req_valid[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDXW'(j);
            end
        end
    end

    // Pointer moves just past the winner; holds when nobody asks.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stitch_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stitch_pipe_arbiter
//  Description : Shares one fixed-latency, no-stall pipeline between NREQ
//                requesters. Round-robin issue, a tag shift register running
//                alongside the pipeline steers each result home.
//  Options     : STITCH_PIPE_ARBITER_PERF_CNT_EN adds per-requester grant
//                counters and a busy-cycle counter with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module stitch_pipe_arbiter
    import stitch_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int RW      = 32,
    parameter int LATENCY = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst,   // asynchronous, active-low
    stitch_pipe_arbiter_if.slave      bus
`ifdef STITCH_PIPE_ARBITER_PERF_CNT_EN
    ,
    input  wire logic                 perf_clr,
    output logic [NREQ*CNT_W-1:0]     grant_cnt,
    output logic [CNT_W-1:0]          busy_cnt
`endif
);

    localparam int MASKW = clog2_min1(LATENCY + 1);

    logic [NREQ-1:0]  arb_grant;
    logic [IDXW-1:0]  arb_idx;
    logic             arb_any;
    logic [NREQ-1:0]  gnt_w;
    logic             issue_w;

    tag_t             tag_q [LATENCY];
    tag_t             tag_d [LATENCY];
    tag_t             head_w;

    logic [MASKW-1:0] mask_q;
    logic [MASKW-1:0] mask_d;
    logic             masked_w;

    logic             err_q;
    logic             err_d;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req_valid (bus.req_valid),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Issue side: outputs are forced low while reset is held.
    always_comb begin
        gnt_w             = rst ? arb_grant : '0;
        issue_w           = rst & arb_any;
        bus.req_ready     = gnt_w;
        bus.pipe_in_valid = issue_w;
        bus.pipe_in_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_w[i]) begin
                bus.pipe_in_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Tag shift register next state: new issue enters, everything moves on.
    always_comb begin
        tag_d[0].vld = issue_w;
        tag_d[0].idx = arb_idx;
        for (int k = 1; k < LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign head_w   = tag_q[LATENCY-1];
    assign masked_w = (mask_q != '0);

    // Post-reset mask countdown and sticky tag/valid disagreement flag.
    always_comb begin
        mask_d = masked_w ? mask_q - MASKW'(1) : mask_q;
        err_d  = err_q | (~masked_w & (bus.pipe_out_valid != head_w.vld));
    end

    // Response demux driven straight from the pipeline outputs.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = rst ? bus.pipe_out_data : '0;
        bus.err_tag   = err_q;
        for (int i = 0; i < NREQ; i++) begin
            if (rst && !masked_w && head_w.vld && bus.pipe_out_valid &&
                (head_w.idx == IDXW'(i))) begin
                bus.rsp_valid[i] = 1'b1;
            end
        end
    end

    // Tag, mask and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            mask_q <= MASKW'(LATENCY);
            err_q  <= 1'b0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end

`ifdef STITCH_PIPE_ARBITER_PERF_CNT_EN
    logic [NREQ-1:0][CNT_W-1:0] grant_cnt_q;
    logic [NREQ-1:0][CNT_W-1:0] grant_cnt_d;
    logic [CNT_W-1:0]           busy_cnt_q;
    logic [CNT_W-1:0]           busy_cnt_d;

    // Saturating counters; clear takes priority over counting.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        busy_cnt_d  = busy_cnt_q;
        if (perf_clr) begin
            grant_cnt_d = '0;
            busy_cnt_d  = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_w[i] && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_d[i] = grant_cnt_q[i] + CNT_W'(1);
                end
            end
            if (issue_w && (busy_cnt_q != '1)) begin
                busy_cnt_d = busy_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign busy_cnt  = busy_cnt_q;
`endif

endmodule
`default_nettype wire
